// File: rtl/adc_axil_pkg.sv
// Shared definitions for the ADC AXI4-Lite slave: register map, bit fields,
// conversion FSM states and the AXI response code.
package adc_axil_pkg;

  // Word indices taken from ADDR[3:2]
  localparam logic [1:0] REG_CTRL    = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_DATA    = 2'd2;
  localparam logic [1:0] REG_SCRATCH = 2'd3;

  localparam int unsigned CTRL_START_BIT = 0;
  localparam int unsigned CTRL_CONT_BIT  = 1;

  localparam int unsigned STAT_BUSY_BIT  = 0;
  localparam int unsigned STAT_VALID_BIT = 1;
  localparam int unsigned STAT_OVR_BIT   = 2;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2
  } conv_state_e;

endpackage

// File: rtl/adc_conv_fsm.sv
// Conversion sequencer: issues one adc_start pulse per conversion and waits
// for the converter's done strobe.
module adc_conv_fsm
  import adc_axil_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic start_req,
  input  logic cont,
  input  logic adc_done,
  output logic adc_start,
  output logic busy_c,
  output logic capture_c
);

  conv_state_e state_q, state_d;
  logic        adc_start_q, adc_start_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      adc_start_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      adc_start_q <= adc_start_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_req || cont) state_d = ST_START;
      ST_START: state_d = ST_WAIT;
      ST_WAIT:  if (adc_done) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    // Registered pulse coincides exactly with the START state
    adc_start_d = (state_d == ST_START);
  end

  assign adc_start = adc_start_q;
  assign busy_c    = (state_q != ST_IDLE);
  assign capture_c = (state_q == ST_WAIT) && adc_done;

endmodule

// File: rtl/adc_axil_slave.sv
// AXI4-Lite register front end for a single-channel ADC: CTRL/STATUS/DATA/SCRATCH
// registers with independent read and write channels.
module adc_axil_slave
  import adc_axil_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int ADC_WIDTH          = 12
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic                            adc_start,
  input  logic                            adc_done,
  input  logic [ADC_WIDTH-1:0]            adc_data
);

  localparam int unsigned DW     = C_S_AXI_DATA_WIDTH;
  localparam int unsigned STRB_W = C_S_AXI_DATA_WIDTH / 8;

  logic          aw_ready_q, aw_ready_d;
  logic          bvalid_q,   bvalid_d;
  logic          ar_ready_q, ar_ready_d;
  logic          rvalid_q,   rvalid_d;
  logic [DW-1:0] rdata_q,    rdata_d;
  logic          cont_q,     cont_d;
  logic          valid_q,    valid_d;
  logic          ovr_q,      ovr_d;
  logic [DW-1:0] data_q,     data_d;
  logic [DW-1:0] scratch_q,  scratch_d;

  logic          wr_en_c, rd_en_c, start_req_c, busy_c, capture_c;
  logic [1:0]    wr_idx, rd_idx;
  logic [DW-1:0] status_c, rd_mux_c;
  logic          unused_c;

  assign wr_en_c  = aw_ready_q & S_AXI_AWVALID & S_AXI_WVALID;
  assign rd_en_c  = ar_ready_q & S_AXI_ARVALID;
  assign wr_idx   = S_AXI_AWADDR[3:2];
  assign rd_idx   = S_AXI_ARADDR[3:2];
  assign unused_c = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  assign start_req_c = wr_en_c && (wr_idx == REG_CTRL) && S_AXI_WSTRB[0]
                       && S_AXI_WDATA[CTRL_START_BIT];

  adc_conv_fsm u_fsm (
    .clk       (S_AXI_ACLK),
    .rst_n     (S_AXI_ARESETN),
    .start_req (start_req_c),
    .cont      (cont_q),
    .adc_done  (adc_done),
    .adc_start (adc_start),
    .busy_c    (busy_c),
    .capture_c (capture_c)
  );

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      aw_ready_q <= 1'b0;
      bvalid_q   <= 1'b0;
      ar_ready_q <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      cont_q     <= 1'b0;
      valid_q    <= 1'b0;
      ovr_q      <= 1'b0;
      data_q     <= '0;
      scratch_q  <= '0;
    end else begin
      aw_ready_q <= aw_ready_d;
      bvalid_q   <= bvalid_d;
      ar_ready_q <= ar_ready_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      cont_q     <= cont_d;
      valid_q    <= valid_d;
      ovr_q      <= ovr_d;
      data_q     <= data_d;
      scratch_q  <= scratch_d;
    end
  end

  always_comb begin
    status_c                 = '0;
    status_c[STAT_BUSY_BIT]  = busy_c;
    status_c[STAT_VALID_BIT] = valid_q;
    status_c[STAT_OVR_BIT]   = ovr_q;

    rd_mux_c = '0;
    case (rd_idx)
      REG_CTRL:    rd_mux_c[CTRL_CONT_BIT] = cont_q;
      REG_STATUS:  rd_mux_c = status_c;
      REG_DATA:    rd_mux_c = data_q;
      REG_SCRATCH: rd_mux_c = scratch_q;
      default:     rd_mux_c = '0;
    endcase
  end

  always_comb begin
    aw_ready_d = ~aw_ready_q & S_AXI_AWVALID & S_AXI_WVALID & ~bvalid_q;
    ar_ready_d = ~ar_ready_q & S_AXI_ARVALID & ~rvalid_q;
    bvalid_d   = bvalid_q;
    rvalid_d   = rvalid_q;
    rdata_d    = rdata_q;
    cont_d     = cont_q;
    valid_d    = valid_q;
    ovr_d      = ovr_q;
    data_d     = data_q;
    scratch_d  = scratch_q;

    if (bvalid_q && S_AXI_BREADY) bvalid_d = 1'b0;
    if (wr_en_c)                  bvalid_d = 1'b1;

    if (rvalid_q && S_AXI_RREADY) rvalid_d = 1'b0;
    if (rd_en_c) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_mux_c;
    end

    if (wr_en_c && (wr_idx == REG_CTRL) && S_AXI_WSTRB[0])
      cont_d = S_AXI_WDATA[CTRL_CONT_BIT];

    for (int unsigned b = 0; b < STRB_W; b++) begin
      if (wr_en_c && (wr_idx == REG_SCRATCH) && S_AXI_WSTRB[b])
        scratch_d[b*8 +: 8] = S_AXI_WDATA[b*8 +: 8];
    end

    // Capture has priority over both clear sources
    if (rd_en_c && (rd_idx == REG_DATA)) valid_d = 1'b0;
    if (capture_c)                       valid_d = 1'b1;

    if (wr_en_c && (wr_idx == REG_STATUS) && S_AXI_WSTRB[0] && S_AXI_WDATA[STAT_OVR_BIT])
      ovr_d = 1'b0;
    if (capture_c && valid_q) ovr_d = 1'b1;

    if (capture_c) data_d = DW'(adc_data);
  end

  assign S_AXI_AWREADY = aw_ready_q;
  assign S_AXI_WREADY  = aw_ready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = RESP_OKAY;
  assign S_AXI_ARREADY = ar_ready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = RESP_OKAY;

endmodule

// File: doc/adc_axil_slave.md
ADC_AXIL_SLAVE -- requirements
Module: adc_axil_slave

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, AXI4-Lite data width (only 32 supported).
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 4, byte address width; 4 word registers.
REQ-003 SHALL have parameter ADC_WIDTH, default 12, converter sample width (1..32).
REQ-004 SHALL have ports, clock and reset first:
- S_AXI_ACLK  in  1  single clock; all logic on rising edge.
- S_AXI_ARESETN  in  1  asynchronous active-low reset.
- S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  write address handshake.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte enables.
- S_AXI_WVALID / S_AXI_WREADY  in / out  1  write data handshake.
- S_AXI_BRESP  out  2  always OKAY (00).
- S_AXI_BVALID / S_AXI_BREADY  out / in  1  write response handshake.
- S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address.
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  read address handshake.
- S_AXI_RDATA  out  32  read data.
- S_AXI_RRESP  out  2  always OKAY (00).
- S_AXI_RVALID / S_AXI_RREADY  out / in  1  read data handshake.
- adc_start  out  1  one-cycle conversion start pulse.
- adc_done  in  1  one-cycle conversion complete strobe.
- adc_data  in  ADC_WIDTH  sample, valid when adc_done=1.

Function
REQ-005 SHALL decode the word index from ADDR[3:2]; ADDR[1:0] ignored. Map: 0x0 CTRL (RW), 0x4 STATUS (RO), 0x8 DATA (RO), 0xC SCRATCH (RW).
REQ-006 SHALL assert AWREADY and WREADY together for exactly one cycle when AWVALID=1, WVALID=1, BVALID=0 and not already ready; the register write commits in that cycle.
REQ-007 SHALL assert BVALID the cycle after the write handshake and hold it until BREADY=1; no new write is accepted while BVALID=1.
REQ-008 SHALL apply WSTRB per byte to RW registers; writes to STATUS/DATA are ignored but still answered OKAY.
REQ-009 SHALL assert ARREADY for one cycle when ARVALID=1 and RVALID=0; RVALID and RDATA are registered the following cycle and held stable until RREADY=1.
REQ-010 SHALL treat read and write channels independently; simultaneous read and write in one cycle both proceed.
REQ-011 CTRL: bit0 START (self-clearing, reads 0), bit1 CONT (continuous mode); other bits read 0.
REQ-012 Conversion FSM states IDLE, START, WAIT: IDLE->START on START write or (CONT=1 in IDLE); START drives adc_start=1 for one cycle ->WAIT; WAIT->IDLE on adc_done, capturing adc_data zero-extended into DATA.
REQ-013 START written while not IDLE SHALL be ignored; clearing CONT does not abort a conversion in progress.
REQ-014 STATUS: bit0 BUSY (FSM != IDLE), bit1 VALID (set on adc_done, cleared by a read of DATA), bit2 OVERRUN (set on adc_done while VALID=1, cleared by a write of 1 to STATUS bit2 — the only STATUS write honoured).
REQ-015 Same-cycle DATA read and adc_done: set wins; VALID remains 1, read returns the old DATA.
REQ-016 adc_done outside WAIT SHALL be ignored.

Reset
REQ-017 On S_AXI_ARESETN=0, asynchronously: all READY/VALID outputs 0, RDATA 0, BRESP/RRESP 00, adc_start 0, CTRL/STATUS/DATA/SCRATCH 0, FSM IDLE.
REQ-018 Reset mid-transaction SHALL drop any pending response; no response is issued after release.

Structure
REQ-019 Shared package adc_axil_pkg SHALL hold register offsets, CTRL/STATUS bit indices, the FSM state enum and the OKAY constant.
REQ-020 The conversion FSM SHALL be one sub-module, adc_conv_fsm; AXI decode and the register file stay in the top module.

Verification
REQ-021 Write 0x11223344 to 0xC, read 0xC -> 0x11223344, BRESP=RRESP=00.
REQ-022 Write 0xFFFFFFFF to 0xC with WSTRB=0010, after 0 -> read 0x0000FF00.
REQ-023 Write 0x1 to 0x0; respond adc_done with adc_data=0xABC 5 cycles after adc_start -> exactly one adc_start pulse, STATUS=0x2, DATA=0x00000ABC, then STATUS=0x0.
REQ-024 CONT=1 with adc_done after each start, no DATA reads -> second sample sets STATUS=0x6; write 0x4 to 0x4 -> STATUS=0x2.
REQ-025 Hold BREADY/RREADY low 10 cycles -> BVALID/RVALID/RDATA stable; AWREADY stays 0 during that time.
REQ-026 Assert S_AXI_ARESETN=0 while in WAIT with BVALID=1 -> all outputs 0 immediately, FSM IDLE, later adc_done ignored.
